face_matrix_scanner: RTL and testbench

//  Parametrised end-of-game face display for the ROWSxCOLS LED matrix, with buzzer tone and restart request.
//  Win shows a smile with a high beep; lose shows a frown with a low beep.

---
 rtl/face_matrix_scanner.sv | 215 +++++++++++++++++++++
 tb/tb_face_matrix_scanner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/face_matrix_scanner.sv
// End-of-game face display: scans a smile/frown over a ROWSxCOLS matrix, beeps, then requests a restart.
// Optional FACE_BLINK_EN blanks the column data in alternate BLINK_DIV-clock windows.
module face_matrix_scanner #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int SCAN_DIV    = 1,
  parameter int BEEP_DIV    = 11,
  parameter int HOLD_CYCLES = 50,
  parameter logic [ROWS*COLS-1:0] WIN_PATTERN  = 64'h1824_4200_6666_6600,
  parameter logic [ROWS*COLS-1:0] LOSE_PATTERN = 64'h4224_1800_6666_6600,
  parameter int BLINK_DIV   = 25
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            success,
  input  logic            fail,
  output logic [ROWS-1:0] hang,
  output logic [COLS-1:0] gre,
  output logic            beep,
  output logic            repeatRst
);

  localparam int ROW_W  = $clog2(ROWS);
  localparam int SCAN_W = $clog2(SCAN_DIV) + 1;
  localparam int BEEP_W = $clog2(2 * BEEP_DIV) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [ROW_W-1:0]  ROW_LAST       = ROW_W'(ROWS - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST      = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BEEP_W-1:0] BEEP_WIN_LAST  = BEEP_W'(BEEP_DIV - 1);
  localparam logic [BEEP_W-1:0] BEEP_LOSE_LAST = BEEP_W'(2 * BEEP_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST      = HOLD_W'(HOLD_CYCLES - 1);

  if (ROWS < 2 || ROWS > 16 || COLS < 2 || COLS > 16 || SCAN_DIV < 1 ||
      BEEP_DIV < 1 || HOLD_CYCLES < 1 || BLINK_DIV < 1) begin : g_param_check
    $error("face_matrix_scanner: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHOW_WIN  = 2'd1,
    ST_SHOW_LOSE = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic                lose_r, lose_nxt_s;
  logic [ROW_W-1:0]    row_r, row_nxt_s, row_step_s;
  logic [SCAN_W-1:0]   scan_r, scan_nxt_s, scan_step_s;
  logic [BEEP_W-1:0]   beep_cnt_r, beep_cnt_nxt_s, beep_cnt_step_s, beep_last_s;
  logic                beep_ph_r, beep_ph_nxt_s, beep_ph_step_s;
  logic [HOLD_W-1:0]   hold_r, hold_nxt_s;
  logic [ROWS-1:0]     hang_r, hang_nxt_s;
  logic [COLS-1:0]     gre_r, gre_nxt_s;
  logic                beep_r, beep_nxt_s, rep_r, rep_nxt_s, blank_nxt_s;
  logic [ROWS*COLS-1:0] pat_s;

  // Free-running step values for the row scanner and the beep divider
  always_comb begin
    scan_step_s = scan_r + 1'b1;
    row_step_s  = row_r;
    if (scan_r == SCAN_LAST) begin
      scan_step_s = '0;
      row_step_s  = (row_r == ROW_LAST) ? '0 : row_r + 1'b1;
    end else begin
      scan_step_s = scan_r + 1'b1;
    end
    beep_last_s = lose_r ? BEEP_LOSE_LAST : BEEP_WIN_LAST;
    if (beep_cnt_r == beep_last_s) begin
      beep_cnt_step_s = '0;
      beep_ph_step_s  = ~beep_ph_r;
    end else begin
      beep_cnt_step_s = beep_cnt_r + 1'b1;
      beep_ph_step_s  = beep_ph_r;
    end
  end

  // Next-state and next-counter selection; entry from IDLE starts every counter at zero
  always_comb begin
    state_nxt_s    = state_r;
    lose_nxt_s     = lose_r;
    row_nxt_s      = '0;
    scan_nxt_s     = '0;
    beep_cnt_nxt_s = '0;
    beep_ph_nxt_s  = 1'b0;
    hold_nxt_s     = hold_r;
    case (state_r)
      ST_IDLE: begin
        hold_nxt_s = '0;
        if (success) begin
          state_nxt_s = ST_SHOW_WIN;
          lose_nxt_s  = 1'b0;
        end else if (fail) begin
          state_nxt_s = ST_SHOW_LOSE;
          lose_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
          lose_nxt_s  = 1'b0;
        end
      end
      ST_SHOW_WIN, ST_SHOW_LOSE: begin
        row_nxt_s      = row_step_s;
        scan_nxt_s     = scan_step_s;
        beep_cnt_nxt_s = beep_cnt_step_s;
        beep_ph_nxt_s  = beep_ph_step_s;
        if (hold_r == HOLD_LAST) begin
          state_nxt_s = ST_DONE;
          hold_nxt_s  = hold_r;
        end else begin
          hold_nxt_s  = hold_r + 1'b1;
        end
      end
      ST_DONE: begin
        row_nxt_s  = row_step_s;
        scan_nxt_s = scan_step_s;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        lose_nxt_s  = 1'b0;
        hold_nxt_s  = '0;
      end
    endcase
  end

`ifdef FACE_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_DIV) + 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  logic [BLINK_W-1:0] blink_cnt_r, blink_cnt_nxt_s;
  logic               blink_ph_r, blink_ph_nxt_s;

  // Blink window divider; phase 0 (pattern visible) on entry
  always_comb begin
    blink_cnt_nxt_s = '0;
    blink_ph_nxt_s  = 1'b0;
    if (state_r == ST_IDLE) begin
      blink_cnt_nxt_s = '0;
      blink_ph_nxt_s  = 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_nxt_s = '0;
      blink_ph_nxt_s  = ~blink_ph_r;
    end else begin
      blink_cnt_nxt_s = blink_cnt_r + 1'b1;
      blink_ph_nxt_s  = blink_ph_r;
    end
  end

  // Blink counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_r <= '0;
      blink_ph_r  <= 1'b0;
    end else begin
      blink_cnt_r <= blink_cnt_nxt_s;
      blink_ph_r  <= blink_ph_nxt_s;
    end
  end

  assign blank_nxt_s = blink_ph_nxt_s;
`else
  assign blank_nxt_s = 1'b0;
`endif

  // Output decode from next state so the first SHOW cycle already shows row 0
  always_comb begin
    pat_s      = lose_nxt_s ? LOSE_PATTERN : WIN_PATTERN;
    hang_nxt_s = '1;
    gre_nxt_s  = '0;
    if (state_nxt_s != ST_IDLE) begin
      for (int r = 0; r < ROWS; r++) begin
        hang_nxt_s[ROWS-1-r] = ~(row_nxt_s == ROW_W'(r));
        gre_nxt_s = gre_nxt_s | ({COLS{row_nxt_s == ROW_W'(r)}} & pat_s[r*COLS +: COLS]);
      end
      gre_nxt_s = blank_nxt_s ? '0 : gre_nxt_s;
    end else begin
      hang_nxt_s = '1;
      gre_nxt_s  = '0;
    end
    beep_nxt_s = beep_ph_nxt_s && (state_nxt_s == ST_SHOW_WIN || state_nxt_s == ST_SHOW_LOSE);
    rep_nxt_s  = (state_nxt_s == ST_DONE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      lose_r     <= 1'b0;
      row_r      <= '0;
      scan_r     <= '0;
      beep_cnt_r <= '0;
      beep_ph_r  <= 1'b0;
      hold_r     <= '0;
      hang_r     <= '1;
      gre_r      <= '0;
      beep_r     <= 1'b0;
      rep_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      lose_r     <= lose_nxt_s;
      row_r      <= row_nxt_s;
      scan_r     <= scan_nxt_s;
      beep_cnt_r <= beep_cnt_nxt_s;
      beep_ph_r  <= beep_ph_nxt_s;
      hold_r     <= hold_nxt_s;
      hang_r     <= hang_nxt_s;
      gre_r      <= gre_nxt_s;
      beep_r     <= beep_nxt_s;
      rep_r      <= rep_nxt_s;
    end
  end

  assign hang      = hang_r;
  assign gre       = gre_r;
  assign beep      = beep_r;
  assign repeatRst = rep_r;

endmodule

// File: tb/tb_face_matrix_scanner.sv
// Scoreboard bench: a default 8x8 scanner plus a 4x6 SCAN_DIV=3 instance (blink checked when FACE_BLINK_EN is set).
module tb_face_matrix_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, success = 1'b0, fail = 1'b0, sb = 1'b0, fb = 1'b0;
  logic [7:0] hang, gre;
  logic       beep, rep;
  logic [3:0] hang_b;
  logic [5:0] gre_b;
  logic       beep_b, rep_b;

  int checks = 0;
  int errors = 0;

  localparam logic [23:0] WIN_B  = {6'h3F, 6'h12, 6'h21, 6'h0C};
  localparam logic [23:0] LOSE_B = {6'h01, 6'h02, 6'h04, 6'h08};

  typedef struct packed {logic [7:0] hang; logic [7:0] gre; logic beep; logic rep;} exp_a_t;
  typedef struct packed {logic [3:0] hang; logic [5:0] gre; logic beep; logic rep;} exp_b_t;
  exp_a_t q_a[$];
  exp_b_t q_b[$];

  face_matrix_scanner dut_a (
    .clk(clk), .rst_n(rst_n), .success(success), .fail(fail),
    .hang(hang), .gre(gre), .beep(beep), .repeatRst(rep)
  );

  face_matrix_scanner #(
    .ROWS(4), .COLS(6), .SCAN_DIV(3), .BEEP_DIV(2), .HOLD_CYCLES(30),
    .WIN_PATTERN(WIN_B), .LOSE_PATTERN(LOSE_B), .BLINK_DIV(5)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .success(sb), .fail(fb),
    .hang(hang_b), .gre(gre_b), .beep(beep_b), .repeatRst(rep_b)
  );

  function automatic exp_a_t model_a(input bit lose, input int k);
    exp_a_t m;
    logic [63:0] pat;
    int row, half;
    pat    = lose ? 64'h4224_1800_6666_6600 : 64'h1824_4200_6666_6600;
    half   = lose ? 22 : 11;
    row    = k % 8;
    m.hang = ~(8'h80 >> row);
    m.gre  = pat[row*8 +: 8];
    m.beep = (k < 50) ? ((k / half) % 2 == 1) : 1'b0;
    m.rep  = (k >= 50);
    return m;
  endfunction

  function automatic exp_b_t model_b(input bit lose, input int k);
    exp_b_t m;
    logic [23:0] pat;
    int row, half;
    pat    = lose ? LOSE_B : WIN_B;
    half   = lose ? 4 : 2;
    row    = (k / 3) % 4;
    m.hang = ~(4'b1000 >> row);
    m.gre  = pat[row*6 +: 6];
`ifdef FACE_BLINK_EN
    if ((k / 5) % 2 == 1) m.gre = 6'h00;
`endif
    m.beep = (k < 30) ? ((k / half) % 2 == 1) : 1'b0;
    m.rep  = (k >= 30);
    return m;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({hang, gre, beep, rep} !== {8'hFF, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_a got hang=%h gre=%h beep=%b rep=%b want ff 00 0 0", hang, gre, beep, rep);
    end
    checks++;
    if ({hang_b, gre_b, beep_b, rep_b} !== {4'hF, 6'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_b got hang=%h gre=%h beep=%b rep=%b want f 00 0 0", hang_b, gre_b, beep_b, rep_b);
    end
    rst_n = 1'b1;
  endtask

  task automatic trig_a(input bit s, input bit f);
    success = s;
    fail    = f;
    @(negedge clk);
    success = 1'b0;
    fail    = 1'b0;
  endtask

  task automatic run_a(input string name, input bit lose, input int n, input bit noise);
    exp_a_t e;
    for (int k = 0; k < n; k++) q_a.push_back(model_a(lose, k));
    for (int k = 0; k < n; k++) begin
      e = q_a.pop_front();
      checks++;
      if ({hang, gre, beep, rep} !== e) begin
        errors++;
        $display("FAIL %s cyc=%0d got hang=%h gre=%h beep=%b rep=%b want hang=%h gre=%h beep=%b rep=%b",
                 name, k, hang, gre, beep, rep, e.hang, e.gre, e.beep, e.rep);
      end
      if (noise) begin
        success = 1'($urandom_range(0, 1));
        fail    = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    success = 1'b0;
    fail    = 1'b0;
  endtask

  task automatic run_b(input string name, input bit lose, input int n);
    exp_b_t e;
    for (int k = 0; k < n; k++) q_b.push_back(model_b(lose, k));
    for (int k = 0; k < n; k++) begin
      e = q_b.pop_front();
      checks++;
      if ({hang_b, gre_b, beep_b, rep_b} !== e) begin
        errors++;
        $display("FAIL %s cyc=%0d got hang=%h gre=%h beep=%b rep=%b want hang=%h gre=%h beep=%b rep=%b",
                 name, k, hang_b, gre_b, beep_b, rep_b, e.hang, e.gre, e.beep, e.rep);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({hang, gre, beep, rep} !== {8'hFF, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL idle_hold got hang=%h gre=%h beep=%b rep=%b want ff 00 0 0", hang, gre, beep, rep);
    end
  endtask

  task automatic test_win();
    do_reset();
    trig_a(1'b1, 1'b0);
    run_a("win", 1'b0, 70, 1'b0);
  endtask

  task automatic test_lose();
    do_reset();
    trig_a(1'b0, 1'b1);
    run_a("lose", 1'b1, 70, 1'b0);
  endtask

  task automatic test_priority_and_ignore();
    do_reset();
    trig_a(1'b1, 1'b1);
    run_a("both_noise", 1'b0, 70, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    trig_a(1'b1, 1'b0);
    run_a("pre_abort", 1'b0, 20, 1'b0);
    do_reset();
    trig_a(1'b1, 1'b0);
    run_a("retrigger", 1'b0, 60, 1'b0);
  endtask

  task automatic test_small_matrix();
    do_reset();
    sb = 1'b1;
    @(negedge clk);
    sb = 1'b0;
    run_b("small_win", 1'b0, 45);
    do_reset();
    fb = 1'b1;
    @(negedge clk);
    fb = 1'b0;
    run_b("small_lose", 1'b1, 40);
  endtask

  initial begin
    test_reset();
    test_win();
    test_lose();
    test_priority_and_ignore();
    test_reset_mid();
    test_small_matrix();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
